// File: rtl/aes_sbox_pkg.sv
// aes_sbox_pkg: shared AES byte-substitution constants, FSM state type and lookup helper.
//   BYTE_W      : byte width
//   SBOX_FWD    : forward S-box table
//   SBOX_INV    : inverse S-box table (only built when SUBSTATE_INV_EN is defined)
//   state_t     : IDLE / RUN / DONE sequencer states
//   sbox_lookup : byte substitution, inverse arm selected by inv under SUBSTATE_INV_EN
// Optional feature macro: SUBSTATE_INV_EN
package aes_sbox_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [BYTE_W-1:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef SUBSTATE_INV_EN
    localparam logic [BYTE_W-1:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

    // Byte substitution; inv is only meaningful when the inverse table exists.
    function automatic logic [BYTE_W-1:0] sbox_lookup(input logic [BYTE_W-1:0] b, input logic inv);
`ifdef SUBSTATE_INV_EN
        return inv ? SBOX_INV[b] : SBOX_FWD[b];
`else
        logic unused_inv;
        unused_inv = inv;
        return SBOX_FWD[b];
`endif
    endfunction

endpackage

// File: rtl/sub_state_seq_if.sv
// sub_state_seq_if: input and output handshakes of the iterative SubBytes stage.
//   in_valid/in_ready/in_state/in_inv     : state offered to the stage
//   out_valid/out_ready/out_state         : substituted state returned by the stage
//   busy                                  : sequencer not idle
// Byte 0 of a state occupies bits [0:7].
interface sub_state_seq_if #(
    parameter int unsigned STATE_BYTES = 16
);
    localparam int unsigned STATE_W = 8 * STATE_BYTES;

    logic               in_valid;
    logic               in_ready;
    logic [0:STATE_W-1] in_state;
    logic               in_inv;
    logic               out_valid;
    logic               out_ready;
    logic [0:STATE_W-1] out_state;
    logic               busy;

    modport master (
        output in_valid, in_state, in_inv, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_inv, out_ready,
        output in_ready, out_valid, out_state, busy
    );

endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational single-byte AES S-box.
//   i_byte   : byte to substitute
//   i_inv    : 1 selects the inverse S-box (effective only with SUBSTATE_INV_EN)
//   o_byte_c : substituted byte (combinational)
module aes_sbox
    import aes_sbox_pkg::*;
(
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_inv,
    output logic [BYTE_W-1:0] o_byte_c
);

    assign o_byte_c = sbox_lookup(i_byte, i_inv);

endmodule

// File: rtl/sub_state_seq.sv
// sub_state_seq: iterative AES SubBytes / InvSubBytes over one state, LANES bytes per cycle.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : sub_state_seq_if slave (input handshake, output handshake, busy)
// Latency from accept to out_valid is STATE_BYTES/LANES cycles.
// Optional feature macro: SUBSTATE_INV_EN (enables the inverse S-box selected by in_inv).
module sub_state_seq
    import aes_sbox_pkg::*;
#(
    parameter int unsigned STATE_BYTES = 16,
    parameter int unsigned LANES       = 4
) (
    input  logic          clk,
    input  logic          rst,
    sub_state_seq_if.slave bus
);

    localparam int unsigned STATE_W = BYTE_W * STATE_BYTES;
    localparam int unsigned N       = STATE_BYTES / LANES;
    localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BIT_W   = (STATE_W > 1) ? $clog2(STATE_W) : 1;

    if (LANES == 0 || (STATE_BYTES % LANES) != 0) begin : g_bad_lanes
        $error("sub_state_seq: LANES must divide STATE_BYTES");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [0:STATE_W-1] r_work;
    logic [0:STATE_W-1] w_work_nxt;
    logic               r_in_ready;
    logic               w_in_ready_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               w_inv_q;

    logic [BYTE_W-1:0]  w_lane_in  [LANES];
    logic [BYTE_W-1:0]  w_lane_out [LANES];

    // Bit offset of the byte served by a lane in the current round slot.
    function automatic logic [BIT_W-1:0] lane_base(input logic [CNT_W-1:0] c, input int unsigned lane);
        return BIT_W'((32'(c) * LANES + lane) * BYTE_W);
    endfunction

`ifdef SUBSTATE_INV_EN
    logic r_inv_q;
    logic w_inv_nxt;
    assign w_inv_q = r_inv_q;
`else
    logic w_unused_inv;
    assign w_unused_inv = bus.in_inv;
    assign w_inv_q      = 1'b0;
`endif

    // Byte mux feeding the shared S-boxes from the cnt-selected slot.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            w_lane_in[l] = r_work[lane_base(r_cnt, l) +: BYTE_W];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .i_byte   (w_lane_in[g]),
            .i_inv    (w_inv_q),
            .o_byte_c (w_lane_out[g])
        );
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_work_nxt  = r_work;
`ifdef SUBSTATE_INV_EN
        w_inv_nxt   = r_inv_q;
`endif
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_work_nxt  = bus.in_state;
`ifdef SUBSTATE_INV_EN
                    w_inv_nxt   = bus.in_inv;
`endif
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    w_work_nxt[lane_base(r_cnt, l) +: BYTE_W] = w_lane_out[l];
                end
                if (r_cnt == CNT_W'(N - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_in_ready_nxt  = (w_state_nxt == IDLE);
        w_out_valid_nxt = (w_state_nxt == DONE);
        w_busy_nxt      = (w_state_nxt != IDLE);
    end

    // State and output registers; reset drops any partially substituted state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SUBSTATE_INV_EN
            r_inv_q     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_work      <= w_work_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
`ifdef SUBSTATE_INV_EN
            r_inv_q     <= w_inv_nxt;
`endif
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_state = r_work;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sub_state_seq.sv
// tb_sub_state_seq: self-checking bench for sub_state_seq (LANES=4 main instance,
// plus LANES=16 and LANES=1 instances). Expected states come from a GF(2^8)
// inverse + affine S-box model or known AES vectors, queued at stimulus time.
module tb_sub_state_seq;

    localparam int unsigned SB = 16;
    localparam int unsigned SW = 8 * SB;
    localparam int          N  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0]    m_fwd [256];
    logic [7:0]    m_inv [256];
    logic [0:SW-1] q_main [$];
    logic [0:SW-1] q16 [$];
    logic [0:SW-1] q1 [$];

    localparam logic [0:SW-1] V2    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:SW-1] V2OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

    sub_state_seq_if #(.STATE_BYTES(SB)) bus   ();
    sub_state_seq_if #(.STATE_BYTES(SB)) bus16 ();
    sub_state_seq_if #(.STATE_BYTES(SB)) bus1  ();

    sub_state_seq #(.STATE_BYTES(SB), .LANES(4))  dut   (.clk(clk), .rst(rst), .bus(bus));
    sub_state_seq #(.STATE_BYTES(SB), .LANES(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    sub_state_seq #(.STATE_BYTES(SB), .LANES(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] model_sbox(input logic [7:0] x);
        logic [7:0] iv, r, s;
        iv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gf_mul(x, 8'(y)) == 8'h01) iv = 8'(y);
        end
        s = iv; r = iv;
        for (int k = 0; k < 4; k++) begin
            r = rotl1(r);
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [0:SW-1] model_sub(input logic [0:SW-1] s, input logic inv);
        logic [0:SW-1] res;
        logic          use_inv;
`ifdef SUBSTATE_INV_EN
        use_inv = inv;
`else
        use_inv = 1'b0 & inv;
`endif
        for (int b = 0; b < SB; b++) begin
            res[8*b +: 8] = use_inv ? m_inv[s[8*b +: 8]] : m_fwd[s[8*b +: 8]];
        end
        return res;
    endfunction

    function automatic logic [0:SW-1] pop_main();
        if (q_main.size() == 0) return 'x;
        return q_main.pop_front();
    endfunction

    task automatic accept(input logic [0:SW-1] s, input logic inv, input logic [0:SW-1] exp);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_wait in_ready=%b want 1", bus.in_ready);
        end
        q_main.push_back(exp);
        bus.in_state = s;
        bus.in_inv   = inv;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_state = V2;
        @(posedge clk); #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_state !== '0) begin n_err++; $display("FAIL reset_out_state got %h want 0", bus.out_state); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        rst = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_zero();
        logic [0:SW-1] exp;
        int lat;
        accept('0, 1'b0, {16{8'h63}});
        wait_out(lat);
        n_cmp++; if (lat != N) begin n_err++; $display("FAIL zero_latency got %0d want %0d", lat, N); end
        exp = pop_main();
        n_cmp++; if (bus.out_state !== exp) begin n_err++; $display("FAIL zero_state got %h want %h", bus.out_state, exp); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL zero_busy got %b want 1", bus.busy); end
        release_out();
    endtask

    task automatic test_vectors();
        logic [0:SW-1] vin [3];
        logic          vinv [3];
        logic [0:SW-1] vexp [3];
        logic [0:SW-1] exp;
        int lat;
        vin[0] = V2;    vinv[0] = 1'b0; vexp[0] = V2OUT;
        vin[1] = V2OUT; vinv[1] = 1'b1;
`ifdef SUBSTATE_INV_EN
        vexp[1] = V2;
`else
        vexp[1] = model_sub(V2OUT, 1'b0);
`endif
        vin[2] = '0;    vinv[2] = 1'b1; vexp[2] = model_sub('0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            accept(vin[i], vinv[i], vexp[i]);
            wait_out(lat);
            n_cmp++; if (lat != N) begin n_err++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, N); end
            exp = pop_main();
            n_cmp++; if (bus.out_state !== exp) begin n_err++; $display("FAIL vec%0d_state got %h want %h", i, bus.out_state, exp); end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        logic [0:SW-1] s, exp;
        logic          inv;
        int lat, prev;
        bus.out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            s   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            accept(s, inv, model_sub(s, inv));
            if (i > 0) begin
                n_cmp++; if (acc_cyc - prev != N + 2) begin n_err++; $display("FAIL b2b%0d_spacing got %0d want %0d", i, acc_cyc - prev, N + 2); end
            end
            prev = acc_cyc;
            wait_out(lat);
            exp = pop_main();
            n_cmp++; if (bus.out_state !== exp) begin n_err++; $display("FAIL b2b%0d_state got %h want %h", i, bus.out_state, exp); end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_hold();
        logic [0:SW-1] s, exp;
        int lat;
        s = {$urandom, $urandom, $urandom, $urandom};
        bus.out_ready = 1'b0;
        accept(s, 1'b0, model_sub(s, 1'b0));
        bus.in_valid = 1'b1;
        bus.in_state = ~s;
        bus.in_inv   = 1'b1;
        wait_out(lat);
        exp = pop_main();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL hold%0d_valid got %b want 1", i, bus.out_valid); end
            n_cmp++; if (bus.out_state !== exp) begin n_err++; $display("FAIL hold%0d_state got %h want %h", i, bus.out_state, exp); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL hold%0d_in_ready got %b want 0", i, bus.in_ready); end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        release_out();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL hold_release_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_abort();
        logic [0:SW-1] s, exp;
        int lat;
        accept(V2, 1'b0, V2OUT);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        q_main.delete();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_state !== '0) begin n_err++; $display("FAIL abort_state got %h want 0", bus.out_state); end
        rst = 1'b0;
        @(posedge clk); #1;
        s = {$urandom, $urandom, $urandom, $urandom};
        accept(s, 1'b0, model_sub(s, 1'b0));
        wait_out(lat);
        n_cmp++; if (lat != N) begin n_err++; $display("FAIL after_abort_latency got %0d want %0d", lat, N); end
        exp = pop_main();
        n_cmp++; if (bus.out_state !== exp) begin n_err++; $display("FAIL after_abort_state got %h want %h", bus.out_state, exp); end
        release_out();
    endtask

    task automatic test_lanes();
        logic [0:SW-1] st16, st1, exp;
        int lat16, lat1;
        lat16 = -1; lat1 = -1; st16 = 'x; st1 = 'x;
        n_cmp++; if (bus16.in_ready !== 1'b1) begin n_err++; $display("FAIL l16_in_ready got %b want 1", bus16.in_ready); end
        n_cmp++; if (bus1.in_ready !== 1'b1) begin n_err++; $display("FAIL l1_in_ready got %b want 1", bus1.in_ready); end
        q16.push_back(V2OUT);
        q1.push_back(V2OUT);
        bus16.in_state = V2; bus16.in_inv = 1'b0; bus16.in_valid = 1'b1;
        bus1.in_state  = V2; bus1.in_inv  = 1'b0; bus1.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0; bus1.in_valid = 1'b0;
        bus16.out_ready = 1'b1; bus1.out_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (lat16 < 0 && bus16.out_valid === 1'b1) begin lat16 = c; st16 = bus16.out_state; end
            if (lat1 < 0 && bus1.out_valid === 1'b1) begin lat1 = c; st1 = bus1.out_state; end
        end
        bus16.out_ready = 1'b0; bus1.out_ready = 1'b0;
        n_cmp++; if (lat16 != 1) begin n_err++; $display("FAIL l16_latency got %0d want 1", lat16); end
        n_cmp++; if (lat1 != 16) begin n_err++; $display("FAIL l1_latency got %0d want 16", lat1); end
        exp = q16.pop_front();
        n_cmp++; if (st16 !== exp) begin n_err++; $display("FAIL l16_state got %h want %h", st16, exp); end
        exp = q1.pop_front();
        n_cmp++; if (st1 !== exp) begin n_err++; $display("FAIL l1_state got %h want %h", st1, exp); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired n_cmp=%0d n_err=%0d", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;   bus.in_state = '0;   bus.in_inv = 1'b0;   bus.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_state = '0; bus16.in_inv = 1'b0; bus16.out_ready = 1'b0;
        bus1.in_valid = 1'b0;  bus1.in_state = '0;  bus1.in_inv = 1'b0;  bus1.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            m_fwd[i] = model_sbox(8'(i));
        end
        for (int i = 0; i < 256; i++) begin
            m_inv[m_fwd[i]] = 8'(i);
        end
        test_reset();
        test_zero();
        test_vectors();
        test_back_to_back();
        test_hold();
        test_abort();
        test_lanes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
